motors_cmd_issuer: RTL and testbench
====================================

Name: motors_cmd_issuer

Overview:
- Initiator side of the motors command handshake; feeds the motors controller one move at a time.
- Buffers upstream move commands (from the G-code/plot path) in a small FIFO.
- Per command: presents fields, pulses trigger once rdy is seen, waits for done, then commits the move into absolute X/Y step-position counters.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >=2.
- PULSE_NUM_X_BITS, 16, width of X pulse count.
- PULSE_NUM_Y_BITS, 16, width of Y pulse count.
- POS_BITS, 24, width of signed absolute position counters; must exceed both pulse widths.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clk_en  in  1  module enable; all state advances only when 1.
- cmd_valid  in  1  upstream command valid.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_pulse_num_x  in  PULSE_NUM_X_BITS  X pulse count (unsigned).
- cmd_dir_x  in  1  X direction; 1 = positive.
- cmd_pulse_num_y  in  PULSE_NUM_Y_BITS  Y pulse count (unsigned).
- cmd_dir_y  in  1  Y direction; 1 = positive.
- cmd_servo_down  in  1  pen state for this move.
- mot_pulse_num_x  out  PULSE_NUM_X_BITS  field to motors controller.
- mot_dir_x  out  1  field to motors controller.
- mot_pulse_num_y  out  PULSE_NUM_Y_BITS  field to motors controller.
- mot_dir_y  out  1  field to motors controller.
- mot_servo_down  out  1  field to motors controller.
- mot_trigger  out  1  one-cycle start strobe.
- mot_rdy  in  1  motors controller idle.
- mot_done  in  1  motors controller finished current move.
- busy  out  1  FIFO non-empty or FSM not in IDLE.
- pos_x  out  POS_BITS  signed absolute X steps.
- pos_y  out  POS_BITS  signed absolute Y steps.

Behaviour:
- Reset values: cmd_ready=1, all mot_* fields=0, mot_trigger=0, busy=0, pos_x=pos_y=0. FIFO is empty and FSM is IDLE.
- Reset mid-move: same reset values apply. The in-flight command and all queued commands are discarded, and no position update occurs.
- clk_en=0: no state change, outputs hold, pushes are not accepted. mot_trigger is never held across clk_en=0; it is asserted only in a clk_en=1 cycle.
- FIFO:
  - cmd_ready = !full, derived from registered count.
  - Push when cmd_valid & cmd_ready & clk_en.
  - No bypass: a pop in the same cycle does not make a full FIFO accept a push.
  - Simultaneous push and pop on a non-full FIFO keeps the count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT_DONE, COMMIT.
  - IDLE: if FIFO not empty and mot_rdy=1, pop the head into the mot_* field registers and go to ISSUE.
  - ISSUE: mot_trigger=1 for exactly this cycle; go to WAIT_DONE.
  - WAIT_DONE: wait for mot_done=1, then go to COMMIT. mot_done is ignored in every other state.
  - COMMIT: update position, then go to IDLE.
- mot_* fields stay stable from the pop until the next pop.
- Latency: FIFO non-empty with mot_rdy=1 in IDLE gives mot_trigger two clk_en cycles after the push cycle. Back-to-back commands need at least 4 cycles plus motor time each.
- Position arithmetic (in COMMIT):
  - pos_x += dir_x ? pulse_num_x : -pulse_num_x, with pulse_num_x zero-extended to POS_BITS.
  - pos_y updates the same way.
  - Two's-complement wrap modulo 2^POS_BITS; no saturation.
- Zero-pulse commands (servo-only) are issued and committed normally, with position unchanged.
- mot_rdy dropping after the pop is ignored; the trigger is still issued.

Test Plan:
- After reset, push {x=100,dir_x=1,y=50,dir_y=0,servo=1} with mot_rdy=1 -> mot_trigger high exactly 1 cycle, fields held. Pulse mot_done -> pos_x=100, pos_y=-50, busy=0.
- Push 4 commands while mot_rdy=0 -> cmd_ready=0 after the 4th, a 5th cmd_valid is not accepted. Raise mot_rdy and ack each with done -> issued in FIFO order, exactly 4 triggers.
- pos_x=0, push x=1,dir_x=0 -> pos_x = 2^24-1 (all ones). With POS_BITS=8 and pos=127, push +1 -> pos wraps to -128.
- Hold clk_en=0 during WAIT_DONE with mot_done=1 -> no COMMIT. clk_en=1 with done -> commit occurs once.
- Assert reset while in WAIT_DONE with 2 entries queued -> all outputs at reset values, cmd_ready=1, no trigger after reset release until a new push.
- Push x=0,y=0,servo=0 -> trigger issued, done commits, positions unchanged. A spurious mot_done pulse in IDLE -> no effect.

Source files
------------

// File: rtl/motors_cmd_issuer.sv
// Queues upstream move commands and hands them to the motors controller one at a time, tracking absolute X/Y position.
// Latency: a push into an idle block with mot_rdy=1 raises mot_trigger two clk_en cycles after the push cycle.
// Backpressure: cmd_ready drops while the FIFO is full; the issue side is paced by mot_rdy and mot_done.
module motors_cmd_issuer #(
  parameter int DEPTH            = 4,
  parameter int PULSE_NUM_X_BITS = 16,
  parameter int PULSE_NUM_Y_BITS = 16,
  parameter int POS_BITS         = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_en,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [PULSE_NUM_X_BITS-1:0] cmd_pulse_num_x,
  input  logic                        cmd_dir_x,
  input  logic [PULSE_NUM_Y_BITS-1:0] cmd_pulse_num_y,
  input  logic                        cmd_dir_y,
  input  logic                        cmd_servo_down,
  output logic [PULSE_NUM_X_BITS-1:0] mot_pulse_num_x,
  output logic                        mot_dir_x,
  output logic [PULSE_NUM_Y_BITS-1:0] mot_pulse_num_y,
  output logic                        mot_dir_y,
  output logic                        mot_servo_down,
  output logic                        mot_trigger,
  input  logic                        mot_rdy,
  input  logic                        mot_done,
  output logic                        busy,
  output logic signed [POS_BITS-1:0]  pos_x,
  output logic signed [POS_BITS-1:0]  pos_y
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PULSE_NUM_X_BITS + PULSE_NUM_Y_BITS + 3;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, COMMIT} state_t;

  state_t               state_q, state_d;
  logic [EW-1:0]        mem_q [DEPTH];
  logic [EW-1:0]        mem_d [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [EW-1:0]        fields_q, fields_d;
  logic [POS_BITS-1:0]  pos_x_q, pos_x_d;
  logic [POS_BITS-1:0]  pos_y_q, pos_y_d;

  logic                 push, pop, commit, fifo_empty;
  logic [EW-1:0]        cmd_entry;
  logic [POS_BITS-1:0]  step_x, step_y;

  assign cmd_entry  = {cmd_servo_down, cmd_dir_y, cmd_pulse_num_y, cmd_dir_x, cmd_pulse_num_x};
  assign fifo_empty = (count_q == '0);
  // Readiness comes from the registered count only, so a same-cycle pop never frees a slot.
  assign cmd_ready  = (count_q != CNT_FULL);
  assign push       = cmd_valid && cmd_ready && clk_en;
  assign busy       = !fifo_empty || (state_q != IDLE);

  assign {mot_servo_down, mot_dir_y, mot_pulse_num_y, mot_dir_x, mot_pulse_num_x} = fields_q;

  // Pulse counts are magnitudes; zero-extend before signed accumulation.
  assign step_x = {{(POS_BITS-PULSE_NUM_X_BITS){1'b0}}, mot_pulse_num_x};
  assign step_y = {{(POS_BITS-PULSE_NUM_Y_BITS){1'b0}}, mot_pulse_num_y};
  assign pos_x  = pos_x_q;
  assign pos_y  = pos_y_q;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; everything freezes while clk_en is low.
  always_comb begin
    state_d = state_q;
    if (clk_en) begin
      case (state_q)
        IDLE:      if (!fifo_empty && mot_rdy) state_d = ISSUE;
        ISSUE:     state_d = WAIT_DONE;
        WAIT_DONE: if (mot_done) state_d = COMMIT;
        COMMIT:    state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // FSM outputs; trigger is gated by clk_en so it can never stretch over a stalled cycle.
  always_comb begin
    pop         = 1'b0;
    commit      = 1'b0;
    mot_trigger = 1'b0;
    if (clk_en) begin
      case (state_q)
        IDLE:    pop = !fifo_empty && mot_rdy;
        ISSUE:   mot_trigger = 1'b1;
        COMMIT:  commit = 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = cmd_entry;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Field latch on pop and position accumulation on commit (two's-complement wrap).
  always_comb begin
    fields_d = pop ? mem_q[rd_ptr_q] : fields_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    if (commit) begin
      pos_x_d = mot_dir_x ? (pos_x_q + step_x) : (pos_x_q - step_x);
      pos_y_d = mot_dir_y ? (pos_y_q + step_y) : (pos_y_q - step_y);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fields_q <= '0;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fields_q <= fields_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
    end
  end

endmodule

// File: tb/tb_motors_cmd_issuer.sv
`timescale 1ns/1ps
module tb_motors_cmd_issuer;

  typedef struct packed {
    logic [15:0] x;
    logic        dx;
    logic [15:0] y;
    logic        dy;
    logic        s;
  } cmd_t;

  typedef struct {
    cmd_t        c;
    logic [23:0] ex;
    logic [23:0] ey;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clk_en, cmd_valid, cmd_ready;
  logic [15:0] cmd_pulse_num_x, cmd_pulse_num_y;
  logic        cmd_dir_x, cmd_dir_y, cmd_servo_down;
  logic [15:0] mot_pulse_num_x, mot_pulse_num_y;
  logic        mot_dir_x, mot_dir_y, mot_servo_down, mot_trigger;
  logic        mot_rdy, mot_done, busy;
  logic [23:0] pos_x, pos_y;

  motors_cmd_issuer dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pulse_num_x(cmd_pulse_num_x), .cmd_dir_x(cmd_dir_x),
    .cmd_pulse_num_y(cmd_pulse_num_y), .cmd_dir_y(cmd_dir_y),
    .cmd_servo_down(cmd_servo_down),
    .mot_pulse_num_x(mot_pulse_num_x), .mot_dir_x(mot_dir_x),
    .mot_pulse_num_y(mot_pulse_num_y), .mot_dir_y(mot_dir_y),
    .mot_servo_down(mot_servo_down), .mot_trigger(mot_trigger),
    .mot_rdy(mot_rdy), .mot_done(mot_done), .busy(busy),
    .pos_x(pos_x), .pos_y(pos_y)
  );

  // Narrow instance for position wrap at POS_BITS=8; controller side always ready/done.
  logic       c8_valid, c8_ready, c8_dx, c8_dy;
  logic [5:0] c8_px, c8_py, m8_px, m8_py;
  logic       m8_dx, m8_dy, m8_s, m8_trig, b8;
  logic       c8_servo = 1'b0;
  logic       rdy8 = 1'b1;
  logic       done8 = 1'b1;
  logic [7:0] p8x, p8y;

  motors_cmd_issuer #(.DEPTH(2), .PULSE_NUM_X_BITS(6), .PULSE_NUM_Y_BITS(6), .POS_BITS(8)) dut8 (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .cmd_valid(c8_valid), .cmd_ready(c8_ready),
    .cmd_pulse_num_x(c8_px), .cmd_dir_x(c8_dx),
    .cmd_pulse_num_y(c8_py), .cmd_dir_y(c8_dy),
    .cmd_servo_down(c8_servo),
    .mot_pulse_num_x(m8_px), .mot_dir_x(m8_dx),
    .mot_pulse_num_y(m8_py), .mot_dir_y(m8_dy),
    .mot_servo_down(m8_s), .mot_trigger(m8_trig),
    .mot_rdy(rdy8), .mot_done(done8), .busy(b8),
    .pos_x(p8x), .pos_y(p8y)
  );

  int total = 0;
  int bad   = 0;
  int trig_cnt = 0;

  always @(posedge clk) if (mot_trigger) trig_cnt <= trig_cnt + 1;

  // Reference model: queue of accepted commands and signed running sums.
  cmd_t   model_q[$];
  longint mx, my;

  function automatic logic [23:0] wrap24(input longint v);
    logic [63:0] t;
    t = v;
    return t[23:0];
  endfunction

  function automatic cmd_t mk(input int x, input int dx, input int y, input int dy, input int s);
    cmd_t c;
    c.x = x[15:0]; c.dx = dx[0]; c.y = y[15:0]; c.dy = dy[0]; c.s = s[0];
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_q.delete();
    mx = 0;
    my = 0;
  endtask

  // Push one command; returns at the negedge following the accepting edge.
  task automatic push(input cmd_t c);
    @(negedge clk);
    check("cmd_ready_before_push", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_pulse_num_x = c.x; cmd_dir_x = c.dx;
    cmd_pulse_num_y = c.y; cmd_dir_y = c.dy;
    cmd_servo_down = c.s;
    @(negedge clk);
    cmd_valid = 1'b0;
    model_q.push_back(c);
  endtask

  // Wait for the trigger of the model's head command, ack it and check the commit.
  task automatic serve();
    cmd_t e;
    bit   seen;
    seen = 1'b0;
    mot_rdy = 1'b1;
    if (model_q.size() == 0) begin
      check("serve_model_nonempty", 64'd0, 64'd1);
      return;
    end
    e = model_q.pop_front();
    for (int n = 0; n < 60 && !seen; n++) begin
      #1;
      if (mot_trigger) seen = 1'b1;
      else @(negedge clk);
    end
    check("trigger_seen", 64'(seen), 64'd1);
    if (!seen) return;
    check("fld_x", 64'(mot_pulse_num_x), 64'(e.x));
    check("fld_dx", 64'(mot_dir_x), 64'(e.dx));
    check("fld_y", 64'(mot_pulse_num_y), 64'(e.y));
    check("fld_dy", 64'(mot_dir_y), 64'(e.dy));
    check("fld_s", 64'(mot_servo_down), 64'(e.s));
    mot_rdy = 1'b0;
    @(negedge clk); #1;
    check("trigger_one_cycle", 64'(mot_trigger), 64'd0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check("pos_x_before_done", 64'(pos_x), 64'(wrap24(mx)));
    mot_done = 1'b1;
    @(negedge clk);
    mot_done = 1'b0;
    @(negedge clk); #1;
    mx = mx + (e.dx ? longint'(e.x) : -longint'(e.x));
    my = my + (e.dy ? longint'(e.y) : -longint'(e.y));
    check("pos_x", 64'(pos_x), 64'(wrap24(mx)));
    check("pos_y", 64'(pos_y), 64'(wrap24(my)));
    check("fld_hold_x", 64'(mot_pulse_num_x), 64'(e.x));
    mot_rdy = 1'b1;
  endtask

  vec_t tbl [5];

  initial begin
    int t0;
    cmd_t c;
    logic [7:0] exp8 [4];
    int inc8 [4];

    reset = 1'b1; clk_en = 1'b1; cmd_valid = 1'b0;
    cmd_pulse_num_x = '0; cmd_dir_x = 1'b0; cmd_pulse_num_y = '0; cmd_dir_y = 1'b0;
    cmd_servo_down = 1'b0; mot_rdy = 1'b1; mot_done = 1'b0;
    c8_valid = 1'b0; c8_px = '0; c8_py = '0; c8_dx = 1'b0; c8_dy = 1'b0;

    tbl[0] = '{mk(100, 1, 50, 0, 1),      24'h000064, 24'hFFFFCE};
    tbl[1] = '{mk(0, 0, 0, 0, 0),         24'h000064, 24'hFFFFCE};
    tbl[2] = '{mk(300, 0, 20, 1, 1),      24'hFFFF38, 24'hFFFFE2};
    tbl[3] = '{mk(65535, 1, 65535, 0, 0), 24'h00FF37, 24'hFEFFE3};
    tbl[4] = '{mk(1, 0, 0, 1, 1),         24'h00FF36, 24'hFEFFE3};

    // Reset values.
    do_reset();
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_trigger", 64'(mot_trigger), 64'd0);
    check("rst_fields", 64'({mot_pulse_num_x, mot_dir_x, mot_pulse_num_y, mot_dir_y, mot_servo_down}), 64'd0);
    check("rst_pos", 64'({pos_x, pos_y}), 64'd0);

    // Table-driven commands, one at a time, with exact trigger latency.
    foreach (tbl[i]) begin
      push(tbl[i].c);
      #1;
      check("lat_first_cycle", 64'(mot_trigger), 64'd0);
      @(negedge clk); #1;
      check("lat_second_cycle", 64'(mot_trigger), 64'd1);
      serve();
      check("tbl_pos_x", 64'(pos_x), 64'(tbl[i].ex));
      check("tbl_pos_y", 64'(pos_y), 64'(tbl[i].ey));
      check("tbl_busy_after", 64'(busy), 64'd0);
    end

    // Fill the FIFO with mot_rdy low; a fifth command must be refused.
    mot_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push(mk(10 + i, i % 2, 20 + i, 1, i % 2));
    #1;
    check("full_cmd_ready", 64'(cmd_ready), 64'd0);
    check("full_busy", 64'(busy), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_pulse_num_x = 16'd999;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    t0 = trig_cnt;
    for (int i = 0; i < 4; i++) serve();
    repeat (10) @(negedge clk);
    #1;
    check("full_trigger_count", 64'(trig_cnt - t0), 64'd4);
    check("full_busy_after", 64'(busy), 64'd0);

    // Negative move from zero wraps to all ones.
    do_reset();
    push(mk(1, 0, 0, 1, 0));
    serve();
    check("wrap_neg_pos_x", 64'(pos_x), 64'hFFFFFF);

    // clk_en low stalls WAIT_DONE even with done asserted; pushes are refused.
    push(mk(5, 1, 7, 1, 1));
    @(negedge clk); #1;
    check("cen_trigger", 64'(mot_trigger), 64'd1);
    c = model_q.pop_front();
    @(negedge clk);
    clk_en = 1'b0; mot_done = 1'b1;
    cmd_valid = 1'b1; cmd_pulse_num_x = 16'd77;
    t0 = trig_cnt;
    repeat (5) begin
      @(negedge clk); #1;
      check("cen_pos_hold", 64'(pos_x), 64'hFFFFFF);
      check("cen_trigger_low", 64'(mot_trigger), 64'd0);
      check("cen_busy", 64'(busy), 64'd1);
    end
    cmd_valid = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);
    mot_done = 1'b0;
    mx = mx + longint'(c.x);
    my = my + longint'(c.y);
    repeat (10) @(negedge clk);
    #1;
    check("cen_commit_once_x", 64'(pos_x), 64'(wrap24(mx)));
    check("cen_commit_once_y", 64'(pos_y), 64'(wrap24(my)));
    check("cen_no_extra_trigger", 64'(trig_cnt - t0), 64'd0);
    check("cen_busy_after", 64'(busy), 64'd0);

    // Reset while waiting for done with two commands queued.
    push(mk(40, 1, 40, 1, 1));
    @(negedge clk);
    @(negedge clk);
    push(mk(41, 1, 1, 1, 0));
    push(mk(42, 0, 2, 0, 1));
    #1;
    check("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_fields", 64'({mot_pulse_num_x, mot_dir_x, mot_pulse_num_y, mot_dir_y, mot_servo_down}), 64'd0);
    check("mid_rst_pos", 64'({pos_x, pos_y}), 64'd0);
    @(negedge clk);
    do_reset();
    t0 = trig_cnt;
    mot_rdy = 1'b1;
    repeat (3) begin
      mot_done = 1'b1; @(negedge clk);
      mot_done = 1'b0; @(negedge clk);
    end
    repeat (8) @(negedge clk);
    #1;
    check("post_rst_no_trigger", 64'(trig_cnt - t0), 64'd0);
    check("post_rst_pos", 64'({pos_x, pos_y}), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);

    // Zero-pulse command, then a spurious done in IDLE.
    push(mk(0, 1, 0, 1, 0));
    serve();
    t0 = trig_cnt;
    mot_done = 1'b1;
    repeat (2) @(negedge clk);
    mot_done = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("spurious_done_pos", 64'({pos_x, pos_y}), 64'd0);
    check("spurious_done_busy", 64'(busy), 64'd0);
    check("spurious_done_trig", 64'(trig_cnt - t0), 64'd0);

    // Randomized bursts checked against the queue/sum model.
    for (int it = 0; it < 25; it++) begin
      int n;
      n = $urandom_range(1, 4);
      mot_rdy = 1'b0;
      for (int k = 0; k < n; k++)
        push(mk($urandom_range(0, 65535), $urandom_range(0, 1), $urandom_range(0, 65535),
                $urandom_range(0, 1), $urandom_range(0, 1)));
      for (int k = 0; k < n; k++) serve();
    end
    check("rand_model_drained", 64'(model_q.size()), 64'd0);

    // POS_BITS=8 instance: 127 + 1 wraps to -128.
    exp8[0] = 8'd63; exp8[1] = 8'd126; exp8[2] = 8'd127; exp8[3] = 8'h80;
    inc8[0] = 63;    inc8[1] = 63;     inc8[2] = 1;      inc8[3] = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      c8_valid = 1'b1; c8_px = inc8[i][5:0]; c8_dx = 1'b1;
      c8_py = (i == 0) ? 6'd1 : 6'd0; c8_dy = 1'b0;
      @(negedge clk);
      c8_valid = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      check("pos8_x", 64'(p8x), 64'(exp8[i]));
      check("pos8_y", 64'(p8y), 64'hFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

endmodule
